// File: rtl/traffic_signal_monitor.sv
// -----------------------------------------------------------------------------
// traffic_signal_monitor
//
// Watches the 8-bit lane-signal bus from the traffic light controller. It
// decodes the phase, locks onto the S0..S7 sequence, and checks each phase
// change against the legal successor and the dwell window for that phase.
// A sticky fault with a cause code is latched on the first violation.
//
// Ports
//   i_clk          single clock, rising edge
//   i_rst          synchronous active-high reset
//   i_signal[7:0]  lane-signal bus (lane 0 in [7:6]; R=00 Y=01 G=10)
//   i_fault_clr    one-cycle request to clear a latched fault
//   o_phase[2:0]   index of the current accepted phase (S0..S7)
//   o_locked       tracking a verified sequence
//   o_phase_pulse  one-cycle pulse on each accepted phase change
//   o_fault        sticky fault flag
//   o_fault_code   1 illegal pattern, 2 bad successor, 3 dwell short,
//                  4 dwell long
//   o_rotations    completed S7->S0 wraps, modulo 256
//   o_state[1:0]   debug view of the FSM state (0 SYNC, 1 TRACK, 2 FAULT)
// -----------------------------------------------------------------------------
module traffic_signal_monitor #(
  parameter int unsigned GREEN_MIN  = 400000,
  parameter int unsigned GREEN_MAX  = 600000,
  parameter int unsigned YELLOW_MIN = 80000,
  parameter int unsigned YELLOW_MAX = 120000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_signal,
  input  logic       i_fault_clr,
  output logic [2:0] o_phase,
  output logic       o_locked,
  output logic       o_phase_pulse,
  output logic       o_fault,
  output logic [2:0] o_fault_code,
  output logic [7:0] o_rotations,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [31:0] G_MIN = 32'(GREEN_MIN);
  localparam logic [31:0] G_MAX = 32'(GREEN_MAX);
  localparam logic [31:0] Y_MIN = 32'(YELLOW_MIN);
  localparam logic [31:0] Y_MAX = 32'(YELLOW_MAX);

  state_t      r_state;
  logic [7:0]  r_sig_q;
  logic [7:0]  r_sig_prev;
  logic [31:0] r_dwell;
  logic [2:0]  r_phase;
  logic        r_locked;
  logic        r_phase_pulse;
  logic        r_fault;
  logic [2:0]  r_fault_code;
  logic [7:0]  r_rotations;

  logic        w_change;
  logic        w_is_rst;
  logic        w_is_phase;
  logic [2:0]  w_idx;
  logic [2:0]  w_exp_next;
  logic [31:0] w_min;
  logic [31:0] w_max;

  assign w_change   = (r_sig_q != r_sig_prev);
  assign w_exp_next = r_phase + 3'd1;

  // Even phases are greens, odd phases are yellows.
  assign w_min = r_phase[0] ? Y_MIN : G_MIN;
  assign w_max = r_phase[0] ? Y_MAX : G_MAX;

  // Pattern decode of the registered sample.
  always_comb begin
    w_is_rst   = 1'b0;
    w_is_phase = 1'b1;
    w_idx      = 3'd0;
    case (r_sig_q)
      8'h55:   begin w_is_rst = 1'b1; w_is_phase = 1'b0; end
      8'h80:   w_idx = 3'd0;
      8'h50:   w_idx = 3'd1;
      8'h20:   w_idx = 3'd2;
      8'h14:   w_idx = 3'd3;
      8'h08:   w_idx = 3'd4;
      8'h05:   w_idx = 3'd5;
      8'h02:   w_idx = 3'd6;
      8'h41:   w_idx = 3'd7;
      default: w_is_phase = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_SYNC;
      r_sig_q       <= 8'd0;
      r_sig_prev    <= 8'd0;
      r_dwell       <= 32'd0;
      r_phase       <= 3'd0;
      r_locked      <= 1'b0;
      r_phase_pulse <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_code  <= 3'd0;
      r_rotations   <= 8'd0;
    end else begin
      r_sig_q       <= i_signal;
      r_sig_prev    <= r_sig_q;
      r_phase_pulse <= 1'b0;

      // When a change is seen, r_dwell holds exactly the number of cycles
      // the previous pattern was sampled.
      if (w_change) begin
        r_dwell <= 32'd1;
      end else if (r_dwell != 32'hFFFF_FFFF) begin
        r_dwell <= r_dwell + 32'd1;
      end

      case (r_state)
        ST_SYNC: begin
          if (w_change && w_is_phase) begin
            r_state  <= ST_TRACK;
            r_phase  <= w_idx;
            r_locked <= 1'b1;
          end
        end

        ST_TRACK: begin
          if (w_change) begin
            if (w_is_rst) begin
              r_state  <= ST_SYNC;
              r_locked <= 1'b0;
            end else if (w_is_phase && (w_idx == w_exp_next) &&
                         (r_dwell >= w_min) && (r_dwell <= w_max)) begin
              r_phase       <= w_idx;
              r_phase_pulse <= 1'b1;
              if (r_phase == 3'd7) begin
                r_rotations <= r_rotations + 8'd1;
              end
            end else begin
              r_state  <= ST_FAULT;
              r_fault  <= 1'b1;
              r_locked <= 1'b0;
              if (!w_is_phase) begin
                r_fault_code <= 3'd1;
              end else if (w_idx != w_exp_next) begin
                r_fault_code <= 3'd2;
              end else if (r_dwell < w_min) begin
                r_fault_code <= 3'd3;
              end else begin
                r_fault_code <= 3'd4;
              end
            end
          end else if (r_dwell >= w_max) begin
            // This edge takes the count to MAX+1: pattern held too long.
            r_state      <= ST_FAULT;
            r_fault      <= 1'b1;
            r_locked     <= 1'b0;
            r_fault_code <= 3'd4;
          end
        end

        ST_FAULT: begin
          if (i_fault_clr) begin
            r_state      <= ST_SYNC;
            r_fault      <= 1'b0;
            r_fault_code <= 3'd0;
          end
        end

        default: r_state <= ST_SYNC;
      endcase
    end
  end

  assign o_phase       = r_phase;
  assign o_locked      = r_locked;
  assign o_phase_pulse = r_phase_pulse;
  assign o_fault       = r_fault;
  assign o_fault_code  = r_fault_code;
  assign o_rotations   = r_rotations;
  assign o_state       = r_state;

endmodule

// File: doc/traffic_signal_monitor.md
# traffic_signal_monitor

Checker and decoder for the 8-bit lane-signal bus driven by the traffic light controller (four lanes, 2-bit code each, lane 0 in bits [7:6]; R=00, Y=01, G=10). It samples the bus, locks onto the phase sequence, and checks every phase change against the legal successor and per-phase dwell windows. It reports the decoded phase, lock status, a sticky fault with cause code, and a rotation count. It sits beside the controller in the top level and feeds status back out on spare outputs.

## Interface
- GREEN_MIN, 400000: minimum legal dwell in clk cycles for a green phase (S0, S2, S4, S6)
- GREEN_MAX, 600000: maximum legal dwell for a green phase
- YELLOW_MIN, 80000: minimum legal dwell for a yellow phase (S1, S3, S5, S7)
- YELLOW_MAX, 120000: maximum legal dwell for a yellow phase
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- signal  in  8  lane-signal bus under test
- fault_clr  in  1  one-cycle request to clear a latched fault
- phase  out  3  index of current accepted phase (0..7 = S0..S7)
- locked  out  1  monitor is tracking a verified sequence
- phase_pulse  out  1  one-cycle pulse on each accepted phase change
- fault  out  1  sticky fault flag
- fault_code  out  3  cause of first fault: 1 illegal pattern, 2 bad successor, 3 dwell short, 4 dwell long
- rotations  out  8  completed S7->S0 wraps, modulo 256

## Operation
- Legal patterns: RST 0x55; S0 0x80, S1 0x50, S2 0x20, S3 0x14, S4 0x08, S5 0x05, S6 0x02, S7 0x41. Successor of Sk is S(k+1 mod 8); successor of RST is S0.
- Input path: sig_q registers signal every cycle; sig_prev registers sig_q; change = (sig_q != sig_prev).
- Dwell counter: 32-bit, saturating; set to 1 on change, else increments. Dwell D of a phase = cycles its pattern was present on signal.
- FSM states: SYNC, TRACK, FAULT.
- SYNC: no checks. On change to 0x55: stay in SYNC, expect S0. On change to any Sk: go TRACK, phase=k, locked=1, counter restarts. Other changes ignored.
- TRACK, on change: new value 0x55 -> SYNC, locked=0, no fault. New value the expected successor and previous D within its window -> accept: phase advances, phase_pulse=1, rotations+1 if S7->S0. Otherwise fault with priority: illegal pattern (1) > wrong successor (2) > D < MIN (3).
- TRACK, no change: counter reaching MAX+1 for current phase class -> fault code 4.
- FAULT: fault=1, locked=0, phase held, checks suspended. fault_clr -> SYNC, fault=0, fault_code=0.
- fault_code captures the first fault only; unchanged until cleared.
- rotations and phase are not reset by fault or fault_clr; only by rst.

## Timing
- rst: all outputs 0, state SYNC, sig_q/sig_prev/counter 0, on the next edge.
- Latency: pattern on signal at edge N is in sig_q at N; phase, phase_pulse, locked, fault update at edge N+1.
- Dwell-long fault: pattern present for MAX+1 cycles -> fault asserts at edge after the (MAX+1)th sample.
- D == MIN and D == MAX both accepted.
- fault_clr coincident with a new fault condition in TRACK: not applicable (FAULT blocks checks); fault_clr in SYNC/TRACK ignored.
- fault_clr on the same edge as FAULT entry: fault wins, stays set.
- rst overrides everything, including fault_clr.
- Counter saturation at 2^32-1: no wrap, no extra faults.

## Test plan
Parameters for all: GREEN_MIN=8, GREEN_MAX=12, YELLOW_MIN=3, YELLOW_MAX=5.
- Reset then 0x55 for 20 cycles, then S0..S7,S0 with greens 10 and yellows 4 cycles -> locked=1 two edges after first 0x80, 8 phase_pulses, rotations=1, fault=0.
- While locked, hold S2 (0x20) 13 cycles -> fault=1, fault_code=4 on edge after 13th sample, locked=0.
- While locked in S1, change to 0x08 after 4 cycles -> fault_code=2; pulse fault_clr -> fault=0, fault_code=0, state SYNC.
- While locked in S0, change to 0x50 after 7 cycles -> fault_code=3; phase stays 0.
- While locked, drive 0xC0 -> fault_code=1; then drive 0x90 -> fault_code still 1.
- Mid-S3, drive 0x55 -> locked=0, fault=0; then 0x80 -> locked=1, phase=0; assert rst mid-phase -> all outputs 0 next edge.
